mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read operands, computes over multiple cycles, and hands the result plus destination address back toward the register file write port. Other units must stall while busy is high.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 154 +++++++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
// The requester drives the master side; the unit drives the slave side.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      dst_addr_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      write_addr;

  modport master (
    output start, funct3, operand_a, operand_b, dst_addr_in,
    input  busy, done, result, write_addr
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, dst_addr_in,
    output busy, done, result, write_addr
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand magnitudes,
// one iteration per clock, with single-cycle fast paths for divide-by-zero and signed overflow.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  mul_div_unit_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(ITERS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg;
  logic [2:0]      op_reg;
  logic            neg_reg;
  logic [XLEN:0]   acc_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] opnd_reg;
  logic [CW-1:0]   count_reg;
  logic [4:0]      dst_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      write_addr_reg;
  logic            busy_reg;
  logic            done_reg;

  // Request decode, evaluated only when a request is accepted in IDLE
  logic            req_div, a_signed, b_signed, req_neg, fast_path;
  logic [XLEN-1:0] a_mag, b_mag, fast_result;

  always_comb begin
    req_div  = bus.funct3[2];
    a_signed = req_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    b_signed = req_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    a_mag    = (a_signed && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
    b_mag    = (b_signed && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;
    if (req_div && bus.funct3[1])
      req_neg = a_signed && bus.operand_a[XLEN-1];
    else
      req_neg = (a_signed && bus.operand_a[XLEN-1]) ^ (b_signed && bus.operand_b[XLEN-1]);
    fast_path   = 1'b0;
    fast_result = '0;
    if (req_div && bus.operand_b == '0) begin
      fast_path   = 1'b1;
      fast_result = bus.funct3[1] ? bus.operand_a : '1;
    end else if (req_div && !bus.funct3[0] && bus.operand_a == MIN_NEG && bus.operand_b == '1) begin
      fast_path   = 1'b1;
      fast_result = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step; the final step also produces the signed-corrected result
  logic [XLEN:0]     mul_sum, div_shift, acc_next;
  logic [XLEN+1:0]   div_diff;
  logic [XLEN-1:0]   lo_next, div_val, div_signed, calc_result;
  logic [2*XLEN-1:0] product, product_signed;

  always_comb begin
    mul_sum   = acc_reg + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {acc_reg[XLEN-1:0], lo_reg[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b0, opnd_reg};
    if (op_reg[2]) begin
      if (!div_diff[XLEN+1]) begin
        acc_next = div_diff[XLEN:0];
        lo_next  = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        acc_next = div_shift;
        lo_next  = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {1'b0, mul_sum[XLEN:1]};
      lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
    product        = {acc_next[XLEN-1:0], lo_next};
    product_signed = neg_reg ? -product : product;
    div_val        = op_reg[1] ? acc_next[XLEN-1:0] : lo_next;
    div_signed     = neg_reg ? -div_val : div_val;
    if (op_reg[2])
      calc_result = div_signed;
    else if (op_reg[1:0] == 2'b00)
      calc_result = product_signed[XLEN-1:0];
    else
      calc_result = product_signed[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      neg_reg        <= 1'b0;
      acc_reg        <= '0;
      lo_reg         <= '0;
      opnd_reg       <= '0;
      count_reg      <= '0;
      dst_reg        <= '0;
      result_reg     <= '0;
      write_addr_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg    <= bus.funct3;
            neg_reg   <= req_neg;
            dst_reg   <= bus.dst_addr_in;
            acc_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            if (fast_path) begin
              result_reg     <= fast_result;
              write_addr_reg <= bus.dst_addr_in;
              done_reg       <= 1'b1;
              state_reg      <= DONE;
            end else begin
              // Divide keeps the divisor in opnd_reg and shifts the dividend out of lo_reg
              opnd_reg  <= req_div ? b_mag : a_mag;
              lo_reg    <= req_div ? a_mag : b_mag;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          lo_reg    <= lo_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(ITERS - 1)) begin
            result_reg     <= calc_result;
            write_addr_reg <= dst_reg;
            done_reg       <= 1'b1;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.result     = result_reg;
  assign bus.write_addr = write_addr_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases plus randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32)) bus ();
  mul_div_unit #(.XLEN(32), .ITERS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: RV32M semantics straight from 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one request and observe the response; inputs are scrambled right after the start edge
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit poke,
                        output logic [31:0] res, output logic [4:0] wa,
                        output int lat, output int busy_cycles, output int done_cnt);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b; bus.dst_addr_in = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
    bus.dst_addr_in = 5'($urandom);
    lat = 0; busy_cycles = 0; done_cnt = 0; res = 'x; wa = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (poke) bus.start = (c == 5);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) begin lat = c; res = bus.result; wa = bus.write_addr; end
      end
      if (!bus.busy && !bus.done) break;
    end
    bus.start = 1'b0;
    $display("op f=%0d a=%h b=%h dst=%0d -> result=%h write_addr=%0d latency=%0d busy=%0d",
             f, a, b, d, res, wa, lat, busy_cycles);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.funct3 = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dst_addr_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result); else pass_cnt++;
    total_cnt++; if (bus.write_addr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", bus.write_addr); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_mul_basic;
    logic [31:0] res; logic [4:0] wa; int lat, bc, dc, extra;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b1, res, wa, lat, bc, dc);
    total_cnt++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_result: got %h want ffffffeb", res); else pass_cnt++;
    total_cnt++; if (wa !== 5'd5) $display("FAIL mul_waddr: got %0d want 5", wa); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL mul_latency: got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (bc != 33) $display("FAIL mul_busy_cycles: got %0d want 33", bc); else pass_cnt++;
    total_cnt++; if (dc != 1) $display("FAIL mul_done_pulses: got %0d want 1", dc); else pass_cnt++;
    extra = 0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
    total_cnt++; if (extra != 0) $display("FAIL mul_ignored_start: got %0d active cycles want 0", extra); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'hFFFFFFEB) $display("FAIL mul_result_hold: got %h want ffffffeb", bus.result); else pass_cnt++;
  endtask

  task automatic test_directed_table(input string name, input logic [2:0] f [], input logic [31:0] a [],
                                     input logic [31:0] b [], input logic [31:0] want [], input int want_lat);
    logic [31:0] res; logic [4:0] wa; int lat, bc, dc; logic [4:0] d;
    for (int i = 0; i < f.size(); i++) begin
      d = 5'($urandom);
      run_op(f[i], a[i], b[i], d, 1'b0, res, wa, lat, bc, dc);
      total_cnt++; if (res !== want[i]) $display("FAIL %s_%0d_result: got %h want %h", name, i, res, want[i]); else pass_cnt++;
      total_cnt++; if (wa !== d) $display("FAIL %s_%0d_waddr: got %0d want %0d", name, i, wa, d); else pass_cnt++;
      total_cnt++; if (lat != want_lat) $display("FAIL %s_%0d_latency: got %0d want %0d", name, i, lat, want_lat); else pass_cnt++;
      total_cnt++; if (bc != want_lat) $display("FAIL %s_%0d_busy_cycles: got %0d want %0d", name, i, bc, want_lat); else pass_cnt++;
    end
  endtask

  task automatic test_high_mul;
    test_directed_table("mulh", '{3'd1, 3'd3, 3'd2}, '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                        '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                        '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF}, 33);
  endtask

  task automatic test_divide;
    test_directed_table("div", '{3'd4, 3'd6, 3'd5, 3'd7},
                        '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9}, '{32'd2, 32'd2, 32'd2, 32'd2},
                        '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001}, 33);
  endtask

  task automatic test_div_zero;
    test_directed_table("divzero", '{3'd4, 3'd6}, '{32'd5, 32'd5}, '{32'd0, 32'd0},
                        '{32'hFFFFFFFF, 32'd5}, 1);
  endtask

  task automatic test_overflow;
    test_directed_table("ovf", '{3'd4, 3'd6}, '{32'h80000000, 32'h80000000}, '{32'hFFFFFFFF, 32'hFFFFFFFF},
                        '{32'h80000000, 32'h0}, 1);
  endtask

  task automatic test_reset_mid;
    logic [31:0] res; logic [4:0] wa; int lat, bc, dc, stray;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.operand_a = 32'hDEADBEEF; bus.operand_b = 32'd13; bus.dst_addr_in = 5'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.result !== 32'h0) $display("FAIL abort_result: got %h want 0", bus.result); else pass_cnt++;
    reset = 1'b0;
    stray = 0;
    repeat (40) begin @(negedge clk); if (bus.done) stray++; end
    total_cnt++; if (stray != 0) $display("FAIL abort_no_done: got %0d pulses want 0", stray); else pass_cnt++;
    run_op(3'd0, 32'd3, 32'd4, 5'd12, 1'b0, res, wa, lat, bc, dc);
    total_cnt++; if (res !== 32'd12) $display("FAIL after_abort_result: got %h want 0000000c", res); else pass_cnt++;
    total_cnt++; if (lat != 33) $display("FAIL after_abort_latency: got %0d want 33", lat); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] res, a, b, want; logic [4:0] wa, d; logic [2:0] f; int lat, bc, dc, want_lat;
    logic [31:0] specials [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 50));
      d = 5'($urandom);
      want = model(f, a, b);
      want_lat = model_lat(f, a, b);
      run_op(f, a, b, d, 1'b0, res, wa, lat, bc, dc);
      total_cnt++; if (res !== want) $display("FAIL rand_%0d_result: f=%0d a=%h b=%h got %h want %h", i, f, a, b, res, want); else pass_cnt++;
      total_cnt++; if (wa !== d) $display("FAIL rand_%0d_waddr: got %0d want %0d", i, wa, d); else pass_cnt++;
      total_cnt++; if (lat != want_lat) $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, want_lat); else pass_cnt++;
      total_cnt++; if (dc != 1) $display("FAIL rand_%0d_done_pulses: got %0d want 1", i, dc); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_high_mul();
    test_divide();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
